// File: rtl/gon_pkg.sv
// GON gather bus shared types; fallback widths apply only when define.svh was not read first.
`ifndef DATA_BITS
`define DATA_BITS 8
`endif
`ifndef XID_BITS
`define XID_BITS 3
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 4
`endif

package gon_pkg;
    localparam int GON_FIFO_DEPTH = 2;
    typedef logic [1:0] gon_count_t;
endpackage

// File: rtl/gon_collect_controller.sv
// One GON column slot: chained ID register, tag comparator and grant qualification.
`ifndef XID_BITS
`define XID_BITS 3
`endif

module gon_collect_controller
    import gon_pkg::*;
#(
    parameter int ID_SIZE = `XID_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_set_id,
    input  logic [ID_SIZE-1:0] i_id,
    output logic [ID_SIZE-1:0] o_id,
    input  logic [ID_SIZE-1:0] i_tag,
    input  logic               i_full,
    input  logic               i_lowerMatched,
    output logic               o_match,
    output logic               o_slave_ready
);

    logic [ID_SIZE-1:0] r_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id <= '0;
        end else if (i_set_id) begin
            r_id <= i_id;
        end
    end

    assign o_id    = r_id;
    assign o_match = (r_id == i_tag);

    // A lower slot that also matches wins, so this slot only grants when it is the first match.
    assign o_slave_ready = o_match & ~i_lowerMatched & ~i_set_id & ~i_full;

endmodule

// File: rtl/gon_bus.sv
// GON gather bus: picks the column whose ID matches tag and queues its words in a 2-entry FIFO.
`ifndef DATA_BITS
`define DATA_BITS 8
`endif
`ifndef XID_BITS
`define XID_BITS 3
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 4
`endif

module gon_bus
    import gon_pkg::*;
#(
    parameter int NUMS_SLAVE = `NUMS_PE_COL,
    parameter int ID_SIZE    = `XID_BITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ID_SIZE-1:0]               tag,
    input  logic [NUMS_SLAVE-1:0]            slave_valid,
    input  logic [NUMS_SLAVE*`DATA_BITS-1:0] slave_data,
    output logic [NUMS_SLAVE-1:0]            slave_ready,
    output logic                             master_valid,
    output logic [`DATA_BITS-1:0]            master_data,
    input  logic                             master_ready,
    input  logic                             set_id,
    input  logic [ID_SIZE-1:0]               ID_scan_in,
    output logic [ID_SIZE-1:0]               ID_scan_out,
    output logic                             err_multi
);

    localparam int DW = `DATA_BITS;

    logic [ID_SIZE-1:0]    w_chain [NUMS_SLAVE+1];
    logic [NUMS_SLAVE-1:0] w_match;
    logic [NUMS_SLAVE-1:0] w_lower;
    logic [NUMS_SLAVE-1:0] w_grant;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_multi;
    logic                  w_selValid;
    logic [DW-1:0]         w_pushData;

    gon_count_t            r_count;
    logic                  r_wrPtr;
    logic                  r_rdPtr;
    logic [DW-1:0]         r_mem [GON_FIFO_DEPTH];
    logic                  r_errMulti;

    assign w_chain[0] = ID_scan_in;
    assign w_full     = (r_count == gon_count_t'(GON_FIFO_DEPTH));

    for (genvar i = 0; i < NUMS_SLAVE; i++) begin : g_slot
        // w_lower[i] flags a match somewhere below slot i.
        if (i == 0) begin : g_first
            assign w_lower[i] = 1'b0;
        end else begin : g_rest
            assign w_lower[i] = |w_match[i-1:0];
        end

        gon_collect_controller #(
            .ID_SIZE(ID_SIZE)
        ) u_ctrl (
            .clk            (clk),
            .rst            (rst),
            .i_set_id       (set_id),
            .i_id           (w_chain[i]),
            .o_id           (w_chain[i+1]),
            .i_tag          (tag),
            .i_full         (w_full),
            .i_lowerMatched (w_lower[i]),
            .o_match        (w_match[i]),
            .o_slave_ready  (w_grant[i])
        );
    end

    assign ID_scan_out = w_chain[NUMS_SLAVE];
    assign slave_ready = w_grant & {NUMS_SLAVE{rst}};

    always_comb begin
        w_pushData = '0;
        for (int i = 0; i < NUMS_SLAVE; i++) begin
            if (w_grant[i]) begin
                w_pushData = slave_data[i*DW +: DW];
            end
        end
    end

    assign w_push     = |(slave_valid & slave_ready);
    assign w_pop      = master_valid & master_ready;
    assign w_selValid = |(slave_valid & w_match & ~w_lower);
    assign w_multi    = |(w_match & w_lower);

    // Full blocks the grant even when a pop happens in the same cycle: no write-through path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_wrPtr    <= 1'b0;
            r_rdPtr    <= 1'b0;
            r_errMulti <= 1'b0;
            for (int k = 0; k < GON_FIFO_DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= w_pushData;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end
            if (w_multi && w_selValid) begin
                r_errMulti <= 1'b1;
            end
        end
    end

    assign master_valid = (r_count != '0);
    assign master_data  = r_mem[r_rdPtr];
    assign err_multi    = r_errMulti;

endmodule

// File: tb/tb_gon_bus.sv
// Self-checking bench for gon_bus: queue-based reference model plus directed and random traffic.
`ifndef DATA_BITS
`define DATA_BITS 8
`endif
`ifndef XID_BITS
`define XID_BITS 3
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 4
`endif

module tb_gon_bus;
    localparam int N   = 4;
    localparam int IDW = 3;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [IDW-1:0]    tag = '0;
    logic [N-1:0]      slave_valid = '0;
    logic [N*DW-1:0]   slave_data = '0;
    logic [N-1:0]      slave_ready;
    logic              master_valid;
    logic [DW-1:0]     master_data;
    logic              master_ready = 1'b0;
    logic              set_id = 1'b0;
    logic [IDW-1:0]    ID_scan_in = '0;
    logic [IDW-1:0]    ID_scan_out;
    logic              err_multi;

    int compCount = 0;
    int failCount = 0;

    logic [IDW-1:0] mIds [N];
    logic [DW-1:0]  mQ [$];
    logic           mErr;

    gon_bus #(.NUMS_SLAVE(N), .ID_SIZE(IDW)) dut (
        .clk          (clk),
        .rst          (rst),
        .tag          (tag),
        .slave_valid  (slave_valid),
        .slave_data   (slave_data),
        .slave_ready  (slave_ready),
        .master_valid (master_valid),
        .master_data  (master_data),
        .master_ready (master_ready),
        .set_id       (set_id),
        .ID_scan_in   (ID_scan_in),
        .ID_scan_out  (ID_scan_out),
        .err_multi    (err_multi)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expected);
        compCount++;
        if (act !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expected, $time);
        end
    endtask

    // Expected grant: first slot whose ID equals tag, unless shifting, full, or in reset.
    function automatic logic [N-1:0] expGrant();
        logic [N-1:0] g;
        g = '0;
        if (rst !== 1'b1 || set_id || mQ.size() >= 2) return g;
        for (int i = 0; i < N; i++) begin
            if (mIds[i] == tag) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) mIds[i] = '0;
        mErr = 1'b0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < N; i++) mIds[i] = '0;
                mQ.delete();
                mErr = 1'b0;
            end else begin
                logic [N-1:0] g;
                int sel;
                int nm;
                g   = expGrant();
                sel = -1;
                nm  = 0;
                for (int i = 0; i < N; i++) begin
                    if (mIds[i] == tag) begin
                        nm++;
                        if (sel < 0) sel = i;
                    end
                end
                if (nm > 1 && slave_valid[sel]) mErr = 1'b1;
                if (mQ.size() > 0 && master_ready) void'(mQ.pop_front());
                for (int i = 0; i < N; i++) begin
                    if (g[i] && slave_valid[i]) mQ.push_back(slave_data[i*DW +: DW]);
                end
                if (set_id) begin
                    for (int i = N-1; i > 0; i--) mIds[i] = mIds[i-1];
                    mIds[0] = ID_scan_in;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("slave_ready", 32'(slave_ready), 32'(expGrant()));
            checkOutput("master_valid", 32'(master_valid), 32'(mQ.size() != 0));
            if (mQ.size() != 0) checkOutput("master_data", 32'(master_data), 32'(mQ[0]));
            checkOutput("ID_scan_out", 32'(ID_scan_out), 32'(mIds[N-1]));
            checkOutput("err_multi", 32'(err_multi), 32'(mErr));
        end
    end

    task automatic applyStimulus(input logic [IDW-1:0] t, input logic [N-1:0] v,
                                 input logic [N*DW-1:0] d, input logic mr,
                                 input logic s, input logic [IDW-1:0] si);
        @(posedge clk);
        #1;
        tag          = t;
        slave_valid  = v;
        slave_data   = d;
        master_ready = mr;
        set_id       = s;
        ID_scan_in   = si;
    endtask

    function automatic logic [N*DW-1:0] colData(input int col, input logic [DW-1:0] val);
        logic [N*DW-1:0] d;
        d = $urandom;
        d[col*DW +: DW] = val;
        return d;
    endfunction

    task automatic loadIds(input logic [IDW-1:0] v0, input logic [IDW-1:0] v1,
                           input logic [IDW-1:0] v2, input logic [IDW-1:0] v3);
        applyStimulus(0, 0, 0, 1, 1, v0);
        applyStimulus(0, 0, 0, 1, 1, v1);
        applyStimulus(0, 0, 0, 1, 1, v2);
        applyStimulus(0, 0, 0, 1, 1, v3);
        applyStimulus(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_master_valid", 32'(master_valid), 32'd0);
        checkOutput("rst_slave_ready", 32'(slave_ready), 32'd0);
        checkOutput("rst_err_multi", 32'(err_multi), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Chain load 3,2,1,0 gives id[0..3] = 0,1,2,3.
        loadIds(3, 2, 1, 0);
        @(negedge clk);
        checkOutput("chain_scan_out", 32'(ID_scan_out), 32'd3);
        for (int k = 0; k < N; k++) begin
            applyStimulus(IDW'(k), 0, 0, 1, 0, 0);
            @(negedge clk);
            checkOutput("chain_grant", 32'(slave_ready), 32'(1 << k));
        end
        applyStimulus(0, 0, 0, 1, 1, 7);
        applyStimulus(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("chain_extra_pulse", 32'(ID_scan_out), 32'd2);
        loadIds(3, 2, 1, 0);

        // Single-source stream with master always ready.
        applyStimulus(2, 4'b0100, colData(2, 8'hA1), 1, 0, 0);
        @(negedge clk);
        checkOutput("stream_ready", 32'(slave_ready), 32'b0100);
        checkOutput("stream_empty", 32'(master_valid), 32'd0);
        applyStimulus(2, 4'b0100, colData(2, 8'hA2), 1, 0, 0);
        @(negedge clk);
        checkOutput("stream_w1", 32'(master_data), 32'hA1);
        applyStimulus(2, 4'b0100, colData(2, 8'hA3), 1, 0, 0);
        @(negedge clk);
        checkOutput("stream_w2", 32'(master_data), 32'hA2);
        applyStimulus(2, 4'b0000, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("stream_w3", 32'(master_data), 32'hA3);
        applyStimulus(2, 4'b0000, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("stream_drained", 32'(master_valid), 32'd0);

        // Backpressure: two accepts, then full holds off the source even across a pop.
        applyStimulus(2, 4'b0100, colData(2, 8'hB1), 0, 0, 0);
        @(negedge clk);
        checkOutput("bp_ready1", 32'(slave_ready), 32'b0100);
        applyStimulus(2, 4'b0100, colData(2, 8'hB2), 0, 0, 0);
        @(negedge clk);
        checkOutput("bp_ready2", 32'(slave_ready), 32'b0100);
        applyStimulus(2, 4'b0100, colData(2, 8'hB3), 0, 0, 0);
        @(negedge clk);
        checkOutput("bp_full_ready", 32'(slave_ready), 32'd0);
        checkOutput("bp_head", 32'(master_data), 32'hB1);
        applyStimulus(2, 4'b0100, colData(2, 8'hB3), 0, 0, 0);
        @(negedge clk);
        checkOutput("bp_head_hold", 32'(master_data), 32'hB1);
        applyStimulus(2, 4'b0100, colData(2, 8'hB3), 1, 0, 0);
        @(negedge clk);
        checkOutput("bp_no_bypass", 32'(slave_ready), 32'd0);
        applyStimulus(2, 4'b0100, colData(2, 8'hB3), 1, 0, 0);
        @(negedge clk);
        checkOutput("bp_w2", 32'(master_data), 32'hB2);
        checkOutput("bp_resume", 32'(slave_ready), 32'b0100);
        applyStimulus(2, 4'b0000, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("bp_w3", 32'(master_data), 32'hB3);
        applyStimulus(2, 4'b0000, 0, 1, 0, 0);

        // Unmatched tag grants nobody.
        repeat (3) begin
            applyStimulus(5, 4'hF, $urandom, 1, 0, 0);
            @(negedge clk);
            checkOutput("nomatch_ready", 32'(slave_ready), 32'd0);
            checkOutput("nomatch_valid", 32'(master_valid), 32'd0);
            checkOutput("nomatch_err", 32'(err_multi), 32'd0);
        end

        // set_id during a stream blocks that cycle; rotating 3 in moves ID 2 to slot 3.
        applyStimulus(2, 4'b0100, colData(2, 8'hC1), 1, 0, 0);
        applyStimulus(2, 4'b0100, colData(2, 8'hC2), 1, 1, 3);
        @(negedge clk);
        checkOutput("setid_block", 32'(slave_ready), 32'd0);
        checkOutput("setid_head", 32'(master_data), 32'hC1);
        applyStimulus(2, 4'b1000, colData(3, 8'hC2), 1, 0, 0);
        @(negedge clk);
        checkOutput("setid_rotated", 32'(slave_ready), 32'b1000);
        applyStimulus(2, 4'b0000, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("setid_word", 32'(master_data), 32'hC2);

        // Multi-match: IDs 1,1,2,3 with tag 1.
        loadIds(3, 2, 1, 1);
        applyStimulus(1, 4'b0011, $urandom, 1, 0, 0);
        @(negedge clk);
        checkOutput("multi_grant", 32'(slave_ready), 32'b0001);
        checkOutput("multi_err_before", 32'(err_multi), 32'd0);
        applyStimulus(1, 4'b0000, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("multi_err_set", 32'(err_multi), 32'd1);
        applyStimulus(3, 4'b0000, 0, 1, 0, 0);
        applyStimulus(3, 4'b0000, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("multi_err_sticky", 32'(err_multi), 32'd1);

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(IDW'($urandom_range(0, 7)), N'($urandom), $urandom,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                          IDW'($urandom_range(0, 7)));
        end

        // Async reset with a full FIFO, asserted between edges.
        loadIds(3, 2, 1, 0);
        applyStimulus(2, 4'b0100, colData(2, 8'hD1), 0, 0, 0);
        applyStimulus(2, 4'b0100, colData(2, 8'hD2), 0, 0, 0);
        applyStimulus(2, 4'b0100, colData(2, 8'hD3), 0, 0, 0);
        @(negedge clk);
        checkOutput("prereset_full", 32'(slave_ready), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("async_master_valid", 32'(master_valid), 32'd0);
        checkOutput("async_slave_ready", 32'(slave_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_valid", 32'(master_valid), 32'd0);
        checkOutput("post_reset_err", 32'(err_multi), 32'd0);
        for (int k = 0; k < N; k++) begin
            applyStimulus(2, 4'b0000, 0, 1, 1, 5);
            @(negedge clk);
            checkOutput("post_reset_chain", 32'(ID_scan_out), 32'd0);
        end
        applyStimulus(2, 4'b0000, 0, 1, 0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule

// File: doc/gon_bus.md
Name: gon_bus

Overview:
- Gather-direction counterpart of the GIN scatter bus: collects data from one PE column at a time and returns it to a single upstream master (GLB write-back / ofmap path).
- Each column slot holds a configured ID loaded through the same shift-chain scheme as GIN. Only the slot whose ID equals `tag` is granted.
- Accepted words pass through a 2-entry output FIFO, so the master side is fully registered.

Parameters:
- NUMS_SLAVE, default `NUMS_PE_COL: number of column slots (sources).
- ID_SIZE, default `XID_BITS: width of the ID and the tag.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- tag  input  ID_SIZE  selects the source column; held stable by the controller for the duration of a gather pass.
- slave_valid  input  NUMS_SLAVE  per-column data-valid.
- slave_data  input  NUMS_SLAVE*`DATA_BITS  per-column data, packed; column i occupies [i*`DATA_BITS +: `DATA_BITS].
- slave_ready  output  NUMS_SLAVE  per-column grant/ready.
- master_valid  output  1  FIFO head valid.
- master_data  output  `DATA_BITS  FIFO head data.
- master_ready  input  1  master accepts the head word.
- set_id  input  1  shift the ID chain by one slot.
- ID_scan_in  input  ID_SIZE  chain input, feeds slot 0.
- ID_scan_out  output  ID_SIZE  chain output, equals the slot NUMS_SLAVE-1 ID.
- err_multi  output  1  sticky flag: more than one slot matched `tag` while a source was valid.

Behaviour:
- Reset (rst=0, async):
  - all slot IDs = 0; FIFO count = 0; FIFO pointers = 0; err_multi = 0.
  - master_valid = 0; slave_ready forced to all-0 while rst is low.
  - Reset mid-transfer discards FIFO contents; no partial word survives.
- ID chain:
  - On a clock edge with set_id=1: id[0] <= ID_scan_in and id[i] <= id[i-1] for i ≥ 1.
  - ID_scan_out = id[NUMS_SLAVE-1], combinational.
  - After NUMS_SLAVE set_id pulses carrying values v0..vN-1 in order, id[i] = v(N-1-i).
- Match and grant (combinational from registered state):
  - match[i] = (id[i] == tag).
  - sel = lowest index with match set.
  - slave_ready[i] = 1 only when all hold: i == sel, set_id == 0, FIFO not full.
  - No match: slave_ready = 0.
  - set_id=1 blocks all grants for that cycle.
- Push: when slave_valid[sel] & slave_ready[sel], write slave_data[sel] to the FIFO tail.
  - Exactly one push per cycle at most.
- Pop: when master_valid & master_ready, advance the head.
  - master_valid = (count != 0); master_data = head entry, registered storage.
  - Head is held stable while master_valid=1 and master_ready=0.
- FIFO bookkeeping:
  - count in 0..2.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers are 1 bit and wrap 1→0.
  - Full (count==2): no grant, even if a pop happens that cycle (no bypass, no write-through).
  - Empty: master_valid=0 and master_data is don't-care; pop is impossible.
- Latency:
  - Source accept at edge k gives master_valid=1 with that word from edge k onward, i.e. one cycle after the handshake was presented.
  - Sustained throughput is 1 word/cycle when master_ready stays high.
- err_multi:
  - Set on any edge where popcount(match) > 1 and slave_valid[sel] = 1.
  - Cleared only by reset.
  - The grant still goes to the lowest-index match.
- Order: words leave in acceptance order. No reordering, no drop, no duplication.

Decomposition:
- DATA_BITS, XID_BITS and NUMS_PE_COL come from the existing define.svh.
- A gon_pkg holds only the FIFO depth constant (2) and a count typedef (logic [1:0]).
- Sub-module: gon_collect_controller, one instance per slot. It contains:
  - the ID register with chain in/out;
  - the match comparator;
  - inputs tag, set_id, full, and a lower-priority-matched input;
  - outputs match and slave_ready.
- The FIFO and the priority chain stay in the top level.

Test Plan:
- ID load (NUMS_SLAVE=4): shift 3,2,1,0 in that order with set_id → id[0..3] = 0,1,2,3 and ID_scan_out = 3.
  - One more pulse with 7 → ID_scan_out = 2.
- Single-source stream: tag=2, slave_valid=4'b0100, data 0xA1, 0xA2, 0xA3, master_ready=1 → slave_ready=4'b0100.
  - master_data shows 0xA1, 0xA2, 0xA3 on consecutive cycles, each one cycle after its accept.
- Backpressure: master_ready=0 with a continuous source → exactly 2 accepts, then slave_ready=0.
  - Head stays at word 1.
  - Raise master_ready → words 1, 2, 3 emerge in order with no loss.
- Non-matching and blocked:
  - tag=5 with all slots valid → slave_ready=0, master_valid stays 0, err_multi stays 0.
  - set_id held high for a cycle during the tag=2 stream → no accept that cycle.
- Multi-match: IDs 1,1,2,3, tag=1, slaves 0 and 1 valid → only slot 0 granted; err_multi=1 from the next edge and stays set.
- Async reset: pull rst low between edges with FIFO count=2 → master_valid=0 and slave_ready=0 immediately.
  - After release, IDs read 0 via the chain, count=0 and err_multi=0.
